// File: rtl/regfile_pkg.sv
// Shared constants, index sizing helper and index type for the regfile_sb register file.
package regfile_pkg;

  localparam int unsigned DEF_WIDTH = 16;
  localparam int unsigned DEF_NREGS = 8;

  // Smallest width able to index nregs entries (ceil(log2)).
  function automatic int unsigned regfile_aw(input int unsigned nregs);
    int unsigned aw;
    aw = 0;
    while ((32'd1 << aw) < nregs) aw++;
    return aw;
  endfunction

  localparam int unsigned DEF_AW = regfile_aw(DEF_NREGS);

  typedef logic [DEF_AW-1:0] reg_idx_t;

endpackage

// File: rtl/regfile_scoreboard.sv
// Per-register pending bits: reserve at issue, clear on writeback; reserve wins on a same-cycle collision.
module regfile_scoreboard
  import regfile_pkg::*;
#(
  parameter int unsigned NREGS = DEF_NREGS,
  parameter int unsigned AW    = regfile_aw(NREGS)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             write_i,
  input  logic [AW-1:0]    writenum_i,
  input  logic             reserve_i,
  input  logic [AW-1:0]    reservenum_i,
  output logic             reserve_ok_o,
  output logic [NREGS-1:0] pending_o
);

  logic [NREGS-1:0] pending_q, pending_d;
  logic             rsv_hit, rsv_pend;

  // rsv_hit stays 0 for an index beyond NREGS, which blocks the reservation.
  always_comb begin
    rsv_hit  = 1'b0;
    rsv_pend = 1'b0;
    for (int unsigned i = 0; i < NREGS; i++) begin
      if (reservenum_i == AW'(i)) begin
        rsv_hit  = 1'b1;
        rsv_pend = pending_q[i];
      end
    end
    reserve_ok_o = reserve_i & rsv_hit &
                   (~rsv_pend | (write_i & (writenum_i == reservenum_i)));
  end

  always_comb begin
    pending_d = pending_q;
    for (int unsigned i = 0; i < NREGS; i++) begin
      if (write_i && (writenum_i == AW'(i)))        pending_d[i] = 1'b0;
      if (reserve_ok_o && (reservenum_i == AW'(i))) pending_d[i] = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) pending_q <= '0;
    else        pending_q <= pending_d;
  end

  assign pending_o = pending_q;

endmodule

// File: rtl/regfile_sb.sv
// Two-read/one-write register file with scoreboard; define REGFILE_BYPASS_EN for write-through forwarding.
module regfile_sb
  import regfile_pkg::*;
#(
  parameter  int unsigned WIDTH = DEF_WIDTH,
  parameter  int unsigned NREGS = DEF_NREGS,
  localparam int unsigned AW    = regfile_aw(NREGS)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] data_in,
  input  logic [AW-1:0]    writenum,
  input  logic             write,
  input  logic [AW-1:0]    readnum_a,
  input  logic [AW-1:0]    readnum_b,
  output logic [WIDTH-1:0] data_out_a,
  output logic [WIDTH-1:0] data_out_b,
  output logic             busy_a,
  output logic             busy_b,
  input  logic             reserve,
  input  logic [AW-1:0]    reservenum,
  output logic             reserve_ok,
  output logic [NREGS-1:0] pending
);

  logic [WIDTH-1:0] mem_q [NREGS];
  logic [WIDTH-1:0] mem_d [NREGS];

  regfile_scoreboard #(
    .NREGS(NREGS),
    .AW   (AW)
  ) u_sb (
    .clk         (clk),
    .rst_n       (rst_n),
    .write_i     (write),
    .writenum_i  (writenum),
    .reserve_i   (reserve),
    .reservenum_i(reservenum),
    .reserve_ok_o(reserve_ok),
    .pending_o   (pending)
  );

  always_comb begin
    mem_d = mem_q;
    for (int unsigned i = 0; i < NREGS; i++) begin
      if (write && (writenum == AW'(i))) mem_d[i] = data_in;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < NREGS; i++) mem_q[i] <= '0;
    end else begin
      mem_q <= mem_d;
    end
  end

  // Indices with no matching entry fall through to the zero defaults.
  always_comb begin
    data_out_a = '0;
    data_out_b = '0;
    busy_a     = 1'b0;
    busy_b     = 1'b0;
    for (int unsigned i = 0; i < NREGS; i++) begin
      if (readnum_a == AW'(i)) begin
        data_out_a = mem_q[i];
        busy_a     = pending[i];
      end
      if (readnum_b == AW'(i)) begin
        data_out_b = mem_q[i];
        busy_b     = pending[i];
      end
`ifdef REGFILE_BYPASS_EN
      if (write && (writenum == AW'(i)) && (readnum_a == AW'(i))) begin
        data_out_a = data_in;
        busy_a     = 1'b0;
      end
      if (write && (writenum == AW'(i)) && (readnum_b == AW'(i))) begin
        data_out_b = data_in;
        busy_b     = 1'b0;
      end
`endif
    end
  end

endmodule

// File: tb/tb_regfile_sb.sv
// Self-checking bench for regfile_sb: directed table, hand sequences and random traffic vs. an array model.
module tb_regfile_sb;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  // Default 8 x 16 instance
  logic [15:0] din8, da8, db8;
  logic [2:0]  wn8, rsn8, ra8, rb8;
  logic        w8, rs8, ba8, bb8, ok8;
  logic [7:0]  pend8;

  // 6 x 32 instance, AW stays 3 so indices 6 and 7 are out of range
  logic [31:0] din6, da6, db6;
  logic [2:0]  wn6, rsn6, ra6, rb6;
  logic        w6, rs6, ba6, bb6, ok6;
  logic [5:0]  pend6;

  regfile_sb u8 (
    .clk(clk), .rst_n(rst_n), .data_in(din8), .writenum(wn8), .write(w8),
    .readnum_a(ra8), .readnum_b(rb8), .data_out_a(da8), .data_out_b(db8),
    .busy_a(ba8), .busy_b(bb8), .reserve(rs8), .reservenum(rsn8),
    .reserve_ok(ok8), .pending(pend8)
  );

  regfile_sb #(.WIDTH(32), .NREGS(6)) u6 (
    .clk(clk), .rst_n(rst_n), .data_in(din6), .writenum(wn6), .write(w6),
    .readnum_a(ra6), .readnum_b(rb6), .data_out_a(da6), .data_out_b(db6),
    .busy_a(ba6), .busy_b(bb6), .reserve(rs6), .reservenum(rsn6),
    .reserve_ok(ok6), .pending(pend6)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: plain arrays of register contents and pending flags
  logic [15:0] m8 [8];
  bit          p8 [8];
  logic [31:0] m6 [6];
  bit          p6 [6];

  function automatic void model_reset();
    for (int i = 0; i < 8; i++) begin m8[i] = '0; p8[i] = 0; end
    for (int i = 0; i < 6; i++) begin m6[i] = '0; p6[i] = 0; end
  endfunction

  function automatic logic [15:0] exp_d8(input int idx);
`ifdef REGFILE_BYPASS_EN
    if (w8 && int'(wn8) == idx) return din8;
`endif
    return m8[idx];
  endfunction

  function automatic bit exp_b8(input int idx);
`ifdef REGFILE_BYPASS_EN
    if (w8 && int'(wn8) == idx) return 0;
`endif
    return p8[idx];
  endfunction

  function automatic logic [31:0] exp_d6(input int idx);
    if (idx >= 6) return '0;
`ifdef REGFILE_BYPASS_EN
    if (w6 && int'(wn6) == idx) return din6;
`endif
    return m6[idx];
  endfunction

  function automatic bit exp_b6(input int idx);
    if (idx >= 6) return 0;
`ifdef REGFILE_BYPASS_EN
    if (w6 && int'(wn6) == idx) return 0;
`endif
    return p6[idx];
  endfunction

  // Drive one cycle on the 8-entry instance, check pre-edge outputs, advance model at the edge.
  task automatic step8(input bit w, input int wn, input logic [15:0] din, input bit rs,
                       input int rsn, input int ra, input int rb, output logic okv);
    bit eok;
    logic [7:0] ep;
    w8 = w; wn8 = 3'(wn); din8 = din; rs8 = rs; rsn8 = 3'(rsn); ra8 = 3'(ra); rb8 = 3'(rb);
    #2;
    eok = rs && (!p8[rsn] || (w && wn == rsn));
    for (int i = 0; i < 8; i++) ep[i] = p8[i];
    chk("u8_ok", {31'd0, ok8}, {31'd0, eok});
    chk("u8_da", {16'd0, da8}, {16'd0, exp_d8(ra)});
    chk("u8_db", {16'd0, db8}, {16'd0, exp_d8(rb)});
    chk("u8_ba", {31'd0, ba8}, {31'd0, exp_b8(ra)});
    chk("u8_bb", {31'd0, bb8}, {31'd0, exp_b8(rb)});
    chk("u8_pend", {24'd0, pend8}, {24'd0, ep});
    okv = ok8;
    @(posedge clk);
    if (w) begin m8[wn] = din; p8[wn] = 0; end
    if (eok) p8[rsn] = 1;
    #1;
  endtask

  task automatic step6(input bit w, input int wn, input logic [31:0] din, input bit rs,
                       input int rsn, input int ra, input int rb);
    bit eok;
    logic [5:0] ep;
    w6 = w; wn6 = 3'(wn); din6 = din; rs6 = rs; rsn6 = 3'(rsn); ra6 = 3'(ra); rb6 = 3'(rb);
    #2;
    eok = rs && rsn < 6 && (!p6[rsn] || (w && wn == rsn));
    for (int i = 0; i < 6; i++) ep[i] = p6[i];
    chk("u6_ok", {31'd0, ok6}, {31'd0, eok});
    chk("u6_da", da6, exp_d6(ra));
    chk("u6_db", db6, exp_d6(rb));
    chk("u6_ba", {31'd0, ba6}, {31'd0, exp_b6(ra)});
    chk("u6_bb", {31'd0, bb6}, {31'd0, exp_b6(rb)});
    chk("u6_pend", {26'd0, pend6}, {26'd0, ep});
    @(posedge clk);
    if (w && wn < 6) begin m6[wn] = din; p6[wn] = 0; end
    if (eok) p6[rsn] = 1;
    #1;
  endtask

  typedef struct {
    bit          w;   int wn;  logic [15:0] din;
    bit          rs;  int rsn; int ra; int rb;
    bit          ok;  logic [15:0] da; logic [15:0] db;
    bit          ba;  bit bb; logic [7:0] pend;
  } vec_t;

  vec_t tbl [9];
  logic okv;

  initial begin
    tbl[0] = '{1, 1, 16'd50984, 0, 0, 1, 2, 0, 16'd50984, 16'd0,     0, 0, 8'h00};
    tbl[1] = '{1, 2, 16'd21131, 0, 0, 1, 2, 0, 16'd50984, 16'd21131, 0, 0, 8'h00};
    tbl[2] = '{0, 0, 16'd0,     0, 0, 1, 1, 0, 16'd50984, 16'd50984, 0, 0, 8'h00};
    tbl[3] = '{0, 0, 16'd0,     1, 3, 3, 3, 1, 16'd0,     16'd0,     1, 1, 8'h08};
    tbl[4] = '{0, 0, 16'd0,     1, 3, 3, 3, 0, 16'd0,     16'd0,     1, 1, 8'h08};
    tbl[5] = '{1, 3, 16'd42,    0, 0, 3, 3, 0, 16'd42,    16'd42,    0, 0, 8'h00};
    tbl[6] = '{0, 0, 16'd0,     1, 4, 4, 1, 1, 16'd0,     16'd50984, 1, 0, 8'h10};
    tbl[7] = '{1, 4, 16'd25126, 1, 4, 4, 4, 1, 16'd25126, 16'd25126, 1, 1, 8'h10};
    tbl[8] = '{1, 7, 16'd34063, 0, 0, 7, 0, 0, 16'd34063, 16'd0,     0, 0, 8'h10};

    rst_n = 1'b0;
    w8 = 0; wn8 = '0; din8 = '0; rs8 = 0; rsn8 = '0; ra8 = '0; rb8 = '0;
    w6 = 0; wn6 = '0; din6 = '0; rs6 = 0; rsn6 = '0; ra6 = '0; rb6 = '0;
    model_reset();
    #3;
    chk("rst_ok", {31'd0, ok8}, 32'd0);
    chk("rst_pend", {24'd0, pend8}, 32'd0);
    chk("rst_da", {16'd0, da8}, 32'd0);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk) #1;

    for (int i = 0; i < 8; i++) begin
      ra8 = 3'(i); rb8 = 3'(i);
      #1;
      chk("sweep_da", {16'd0, da8}, 32'd0);
      chk("sweep_db", {16'd0, db8}, 32'd0);
      chk("sweep_busy", {30'd0, ba8, bb8}, 32'd0);
      chk("sweep_pend", {24'd0, pend8}, 32'd0);
    end
    @(posedge clk) #1;

    foreach (tbl[r]) begin
      step8(tbl[r].w, tbl[r].wn, tbl[r].din, tbl[r].rs, tbl[r].rsn, tbl[r].ra, tbl[r].rb, okv);
      chk("tbl_ok", {31'd0, okv}, {31'd0, tbl[r].ok});
      w8 = 0; rs8 = 0; ra8 = 3'(tbl[r].ra); rb8 = 3'(tbl[r].rb);
      #2;
      chk("tbl_da", {16'd0, da8}, {16'd0, tbl[r].da});
      chk("tbl_db", {16'd0, db8}, {16'd0, tbl[r].db});
      chk("tbl_busy", {30'd0, ba8, bb8}, {30'd0, tbl[r].ba, tbl[r].bb});
      chk("tbl_pend", {24'd0, pend8}, {24'd0, tbl[r].pend});
    end

    // Forwarding: r7 reserved, then written while both ports read it
    step8(0, 0, 16'd0, 1, 7, 7, 7, okv);
    w8 = 1; wn8 = 3'd7; din8 = 16'd1000; rs8 = 0; ra8 = 3'd7; rb8 = 3'd7;
    #2;
`ifdef REGFILE_BYPASS_EN
    chk("byp_pre_da", {16'd0, da8}, 32'd1000);
    chk("byp_pre_ba", {31'd0, ba8}, 32'd0);
`else
    chk("byp_pre_da", {16'd0, da8}, 32'd34063);
    chk("byp_pre_ba", {31'd0, ba8}, 32'd1);
`endif
    @(posedge clk);
    m8[7] = 16'd1000; p8[7] = 0;
    #1; w8 = 0;
    #1;
    chk("byp_post_da", {16'd0, da8}, 32'd1000);
    chk("byp_post_bb", {31'd0, bb8}, 32'd0);

    // Asynchronous reset in the middle of a write cycle
    @(posedge clk) #1;
    w8 = 1; wn8 = 3'd1; din8 = 16'd5; ra8 = 3'd1; rb8 = 3'd4;
    #2 rst_n = 1'b0;
    #1;
    chk("midrst_da", {16'd0, da8}, 32'd0);
    chk("midrst_bb", {31'd0, bb8}, 32'd0);
    chk("midrst_pend", {24'd0, pend8}, 32'd0);
    @(posedge clk) #1;
    w8 = 0; rst_n = 1'b1;
    model_reset();
    #2;
    chk("midrst_discard", {16'd0, da8}, 32'd0);
    @(posedge clk) #1;

    for (int n = 0; n < 400; n++) begin
      step8(bit'($urandom_range(0, 1)), int'($urandom_range(0, 7)), 16'($urandom),
            bit'($urandom_range(0, 1)), int'($urandom_range(0, 7)),
            int'($urandom_range(0, 7)), int'($urandom_range(0, 7)), okv);
    end
    w8 = 0; rs8 = 0;

    // 6-entry instance: out-of-range indices
    step6(1, 7, 32'hDEADBEEF, 0, 0, 0, 0);
    w6 = 0;
    for (int i = 0; i < 8; i++) begin
      ra6 = 3'(i); rb6 = 3'(7 - i);
      #1;
      chk("oor_da", da6, 32'd0);
      chk("oor_db", db6, 32'd0);
      chk("oor_busy", {30'd0, ba6, bb6}, 32'd0);
    end
    chk("oor_pend", {26'd0, pend6}, 32'd0);
    @(posedge clk) #1;
    rs6 = 1; rsn6 = 3'd6;
    #1 chk("oor_rsv6", {31'd0, ok6}, 32'd0);
    rsn6 = 3'd7;
    #1 chk("oor_rsv7", {31'd0, ok6}, 32'd0);
    rsn6 = 3'd5;
    #1 chk("rsv5_ok", {31'd0, ok6}, 32'd1);
    rs6 = 0;
    @(posedge clk) #1;

    for (int n = 0; n < 300; n++) begin
      step6(bit'($urandom_range(0, 1)), int'($urandom_range(0, 7)), $urandom,
            bit'($urandom_range(0, 1)), int'($urandom_range(0, 7)),
            int'($urandom_range(0, 7)), int'($urandom_range(0, 7)));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
